// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: one load/store request -> one req/ack bus transaction.
// Latency: start at cycle 0, bus_req from cycle 1, ack at cycle k, done at cycle k+1.
// Backpressure: busy stalls the datapath from the accepting cycle until done; bus_req holds until ack or timeout.
//
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_start/i_we/i_size/...    request from EX/MEM (size: 00 word, 01 half, 10 byte, 11 word)
//   o_busy, o_done, o_rdata    datapath handshake and extended load data
//   o_misalign, o_bus_err      error pulses, coincident with o_done
//   o_bus_*, i_bus_*           data-memory bus (req held until ack)
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_ld_uns,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;
  logic          r_uns;
  logic          r_done, r_misalign, r_bus_err, r_bus_req, r_bus_we;
  logic [31:0]   r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]    r_bus_be;

  logic          w_mis, w_accept, w_mis_acc, w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ld_ext;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // Request decode: alignment, byte enables and lane-replicated store data.
  always_comb begin
    w_mis   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    case (i_size)
      2'b10: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_mis   = i_addr[0];
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: w_mis = |i_addr[1:0];
    endcase
  end

  // Load extraction uses the latched size/lane, since bus_rdata arrives cycles after start.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (r_size)
      2'b10:   w_ld_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ld_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ld_ext = i_bus_rdata;
    endcase
  end

  // Next-state logic. Ack is checked before expiry so an ack on the last cycle still succeeds.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mis_acc   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = ~w_mis;
          w_mis_acc   = w_mis;
          w_state_nxt = w_mis ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (i_bus_ack) begin
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_uns       <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= (w_state_nxt == S_RESP) || (w_state_nxt == S_ERR);
      r_misalign <= w_mis_acc;
      r_bus_err  <= w_timeout;
      r_bus_req  <= (w_state_nxt == S_REQ);
      if (w_accept) begin
        r_cnt       <= '0;
        r_size      <= i_size;
        r_lane      <= i_addr[1:0];
        r_uns       <= i_ld_uns;
        r_bus_we    <= i_we;
        r_bus_addr  <= {i_addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_REQ && i_bus_ack && !r_bus_we) begin
        r_rdata <= w_ld_ext;
      end
    end
  end

  // busy must already be high in the accepting cycle so the datapath freezes the request.
  assign o_busy      = ~i_rst & ((r_state == S_REQ) | ((r_state == S_IDLE) & i_start));
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalign, timeout, async reset.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        start, we, ld_uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_start(start), .i_we(we), .i_size(size), .i_ld_uns(ld_uns),
    .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_misalign(misalign), .o_bus_err(bus_err),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with ack at cycle 2; called at a drive point while IDLE.
  task automatic run_txn(input string tag, input logic we_i, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [31:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd);
    start = 1'b1; we = we_i; size = sz; ld_uns = uns; addr = a; wdata = wd;
    @(negedge clk);
    chk({tag, "_busy_c0"}, busy, 1);
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_addr"}, bus_addr, exp_addr);
    chk({tag, "_be"}, bus_be, exp_be);
    chk({tag, "_we"}, bus_we, we_i);
    if (we_i) chk({tag, "_wdata"}, bus_wdata, exp_wd);
    next_cyc();
    bus_ack = 1'b1; bus_rdata = rd;
    next_cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_flags"}, {misalign, bus_err, bus_req}, 0);
    chk({tag, "_rdata"}, rdata, exp_rd);
    next_cyc();
  endtask

  initial begin
    int n_req;
    bit got_done;

    rst = 1'b1; start = 1'b0; we = 1'b0; size = 2'b00; ld_uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #2;
    chk("rst_outs", {31'd0, busy | done | misalign | bus_err | bus_req | bus_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", bus_addr | bus_wdata | {28'd0, bus_be}, 0);
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // bus_ack while idle must not start anything
    bus_ack = 1'b1;
    next_cyc();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack", {30'd0, done, bus_req}, 0);
    next_cyc();

    // sw 0x100, ack at cycle 4 -> done cycle 5, busy high 0..4
    start = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h100; wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sw_busy_c0", busy, 1);
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk("sw_req_c1", bus_req, 1);
    chk("sw_be", bus_be, 4'b1111);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_we", bus_we, 1);
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("sw_busy_c3", {30'd0, busy, bus_req}, 2'b11);
    next_cyc();
    bus_ack = 1'b1;
    @(negedge clk);
    chk("sw_busy_c4", {30'd0, busy, done}, 2'b10);
    next_cyc();
    bus_ack = 1'b0;
    start = 1'b1; we = 1'b0; addr = 32'h0;   // start during RESP is ignored
    @(negedge clk);
    chk("sw_done_c5", {29'd0, done, busy, bus_req}, 3'b100);
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk("resp_start_ign", {30'd0, bus_req, done}, 0);
    next_cyc();

    run_txn("sb",  1'b1, 2'b10, 1'b0, 32'h203, 32'h000000A5, 32'h0,
            32'h200, 32'b1000, 32'hA5A5A5A5, 32'h0);
    run_txn("sh",  1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0,
            32'h100, 32'b1100, 32'hABCDABCD, 32'h0);
    run_txn("lb",  1'b0, 2'b10, 1'b0, 32'h202, 32'h0, 32'h12F05634,
            32'h200, 32'b0100, 32'h0, 32'hFFFFFFF0);
    run_txn("lbu", 1'b0, 2'b10, 1'b1, 32'h202, 32'h0, 32'h12F05634,
            32'h200, 32'b0100, 32'h0, 32'h000000F0);
    run_txn("lhu", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h12F05634,
            32'h200, 32'b1100, 32'h0, 32'h000012F0);
    run_txn("lh",  1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00008001,
            32'h200, 32'b0011, 32'h0, 32'hFFFF8001);
    run_txn("lw11", 1'b0, 2'b11, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D,
            32'h204, 32'b1111, 32'h0, 32'hCAFEF00D);

    // lh at odd address: misalign + done at cycle 1, no bus activity, rdata kept
    start = 1'b1; we = 1'b0; size = 2'b01; ld_uns = 1'b0; addr = 32'h101;
    @(negedge clk);
    chk("mis_busy_c0", busy, 1);
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk("mis_done", {29'd0, done, misalign, bus_err}, 3'b110);
    chk("mis_noreq", {30'd0, bus_req, busy}, 0);
    chk("mis_rdata", rdata, 32'hCAFEF00D);
    next_cyc();
    @(negedge clk);
    chk("mis_pulse", {30'd0, done, misalign}, 0);
    next_cyc();

    // Load with no ack: bus_req for 16 cycles, then bus_err + done
    start = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h300;
    next_cyc();
    start = 1'b0;
    n_req = 0; got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      if (bus_req) n_req++;
      if (done) begin
        got_done = 1;
        chk("to_err", {30'd0, bus_err, misalign}, 2'b10);
        chk("to_rdata", rdata, 32'hCAFEF00D);
      end
    end
    chk("to_req_cycles", n_req, 16);
    chk("to_done_seen", {31'd0, got_done}, 1);
    next_cyc();

    // Ack on the last permitted cycle still succeeds
    start = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h400;
    next_cyc();
    start = 1'b0;
    repeat (15) next_cyc();
    @(negedge clk);
    chk("last_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'h600DF00D;
    next_cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("last_ack", {29'd0, done, bus_err, misalign}, 3'b100);
    chk("last_rdata", rdata, 32'h600DF00D);
    next_cyc();

    run_txn("after", 1'b1, 2'b10, 1'b0, 32'h001, 32'h0000003C, 32'h0,
            32'h000, 32'b0010, 32'h3C3C3C3C, 32'h600DF00D);

    // Async reset during REQ: bus_req/busy drop at once, no done, later ack ignored
    start = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h500;
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk("ar_req", bus_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_drop", {30'd0, bus_req, busy}, 0);
    chk("ar_nodone", done, 0);
    next_cyc();
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ar_ack_ign", {30'd0, done, bus_req}, 0);
    end
    bus_ack = 1'b0;
    chk("ar_rdata", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
